// File: rtl/subterranean_din_packer.sv
// Packs a byte-serial stream into 32-bit little-endian words for the Subterranean din bus.
// Optional statistics counters are enabled with SUBTERRANEAN_DIN_PACKER_STATS_EN.
module subterranean_din_packer #(
  parameter int unsigned G_MAX_WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic [7:0]  s_data,
  input  logic        s_empty,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] din,
  output logic [2:0]  din_size,
  output logic        din_last,
  output logic        din_valid,
  input  logic        din_ready
`ifdef SUBTERRANEAN_DIN_PACKER_STATS_EN
  ,
  output logic [15:0] word_count,
  output logic [15:0] msg_count
`endif
);

  localparam int unsigned W_WORD = 32;
  localparam int unsigned W_CNT  = 3;
  localparam logic [W_CNT-1:0] MAX_CNT = W_CNT'(G_MAX_WORD_BYTES);

  logic [W_WORD-1:0] acc, acc_n;
  logic [W_CNT-1:0]  acc_cnt, acc_cnt_n;
  logic              acc_last, acc_last_n;
  logic              acc_done, acc_done_n;
  logic [W_WORD-1:0] din_n;
  logic [W_CNT-1:0]  din_size_n;
  logic              din_last_n;
  logic              din_valid_n;

  logic accept, xfer, pop;

  // Stall only when both the finished accumulator and the holding register are occupied.
  assign s_ready = ~acc_done | ~din_valid;
  assign accept  = s_valid & s_ready;
  assign xfer    = acc_done & (~din_valid | din_ready);
  assign pop     = din_valid & din_ready;

  always_comb begin
    acc_n       = acc;
    acc_cnt_n   = acc_cnt;
    acc_last_n  = acc_last;
    acc_done_n  = acc_done;
    din_n       = din;
    din_size_n  = din_size;
    din_last_n  = din_last;
    din_valid_n = din_valid;

    if (xfer) begin
      din_n       = acc;
      din_size_n  = acc_cnt;
      din_last_n  = acc_last;
      din_valid_n = 1'b1;
      acc_n       = '0;
      acc_cnt_n   = '0;
      acc_last_n  = 1'b0;
      acc_done_n  = 1'b0;
    end else if (pop) begin
      din_valid_n = 1'b0;
    end

    // An accepted beat lands on top of the (possibly just cleared) accumulator.
    if (accept) begin
      if (!s_empty) begin
        acc_n[{acc_cnt_n[1:0], 3'b000} +: 8] = s_data;
        acc_cnt_n  = acc_cnt_n + 3'd1;
        acc_done_n = (acc_cnt_n == MAX_CNT) || s_last;
        acc_last_n = s_last;
      end else if (s_last) begin
        acc_done_n = 1'b1;
        acc_last_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      acc       <= '0;
      acc_cnt   <= '0;
      acc_last  <= 1'b0;
      acc_done  <= 1'b0;
      din       <= '0;
      din_size  <= '0;
      din_last  <= 1'b0;
      din_valid <= 1'b0;
    end else begin
      acc       <= acc_n;
      acc_cnt   <= acc_cnt_n;
      acc_last  <= acc_last_n;
      acc_done  <= acc_done_n;
      din       <= din_n;
      din_size  <= din_size_n;
      din_last  <= din_last_n;
      din_valid <= din_valid_n;
    end
  end

`ifdef SUBTERRANEAN_DIN_PACKER_STATS_EN
  // Saturating counts of words and messages taken by the core.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      word_count <= '0;
      msg_count  <= '0;
    end else if (pop) begin
      if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
      if (din_last && (msg_count != 16'hFFFF)) msg_count <= msg_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_subterranean_din_packer.sv
// Randomized and directed bench for subterranean_din_packer against a word-level queue model.
module tb_subterranean_din_packer;

  localparam int unsigned G = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       empty;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  size;
    logic        last;
    int unsigned ready_at;
  } word_t;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_empty = 1'b0, s_last = 1'b0, s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] din;
  logic [2:0]  din_size;
  logic        din_last, din_valid;
  logic        din_ready = 1'b1;

  logic [7:0]  s1_data = '0;
  logic        s1_last = 1'b0, s1_valid = 1'b0, s1_ready;
  logic [31:0] d1;
  logic [2:0]  d1_size;
  logic        d1_last, d1_valid;

`ifdef SUBTERRANEAN_DIN_PACKER_STATS_EN
  logic [15:0] word_count, msg_count, wc1, mc1;
`endif

  subterranean_din_packer #(.G_MAX_WORD_BYTES(G)) u_dut (
    .clk(clk), .arstn(arstn),
    .s_data(s_data), .s_empty(s_empty), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .din(din), .din_size(din_size), .din_last(din_last), .din_valid(din_valid), .din_ready(din_ready)
`ifdef SUBTERRANEAN_DIN_PACKER_STATS_EN
    , .word_count(word_count), .msg_count(msg_count)
`endif
  );

  subterranean_din_packer #(.G_MAX_WORD_BYTES(1)) u_dut1 (
    .clk(clk), .arstn(arstn),
    .s_data(s1_data), .s_empty(1'b0), .s_last(s1_last), .s_valid(s1_valid), .s_ready(s1_ready),
    .din(d1), .din_size(d1_size), .din_last(d1_last), .din_valid(d1_valid), .din_ready(1'b1)
`ifdef SUBTERRANEAN_DIN_PACKER_STATS_EN
    , .word_count(wc1), .msg_count(mc1)
`endif
  );

  always #5 clk = ~clk;

  beat_t       stim_q[$];
  word_t       exp_q[$];
  word_t       log_q[$];
  logic [7:0]  cur_q[$];
  int unsigned edge_n = 0, n_acc = 0, n_pops = 0, n_msgs = 0;
  int unsigned valid_pct = 100, ready_pct = 100;
  int          n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is complete when G bytes are gathered or the message ends.
  task automatic complete_word(input int unsigned e, input logic last);
    word_t w;
    w = '0;
    for (int i = 0; i < cur_q.size(); i++) w.data[8*i +: 8] = cur_q[i];
    w.size     = 3'(cur_q.size());
    w.last     = last;
    w.ready_at = e + 1;
    exp_q.push_back(w);
    cur_q.delete();
  endtask

  task automatic model_beat(input beat_t b, input int unsigned e);
    if (!b.empty) begin
      cur_q.push_back(b.data);
      if (cur_q.size() == G || b.last) complete_word(e, b.last);
    end else if (b.last) begin
      complete_word(e, 1'b1);
    end
  endtask

  // One cycle: check outputs at the falling edge, drive inputs, advance the model.
  task automatic step();
    logic  exp_valid, exp_ready;
    beat_t b;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].ready_at <= edge_n);
    exp_ready = exp_q.size() < 2;
    chk("s_ready", 32'(s_ready), 32'(exp_ready));
    chk("din_valid", 32'(din_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("din", din, exp_q[0].data);
      chk("din_size", 32'(din_size), 32'(exp_q[0].size));
      chk("din_last", 32'(din_last), 32'(exp_q[0].last));
    end
    s_valid = (stim_q.size() > 0) && ($urandom_range(99) < valid_pct);
    if (s_valid) begin
      s_data  = stim_q[0].data;
      s_empty = stim_q[0].empty;
      s_last  = stim_q[0].last;
    end else begin
      s_data  = 8'($urandom);
      s_empty = 1'b0;
      s_last  = 1'b0;
    end
    din_ready = $urandom_range(99) < ready_pct;
    if (exp_valid && din_ready) begin
      log_q.push_back(exp_q[0]);
      n_pops++;
      if (exp_q[0].last) n_msgs++;
      void'(exp_q.pop_front());
    end
    if (s_valid && exp_ready) begin
      b = stim_q.pop_front();
      n_acc++;
      model_beat(b, edge_n + 1);
    end
    edge_n++;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n, input logic with_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data  = first + 8'(i);
      b.empty = 1'b0;
      b.last  = with_last && (i == n - 1);
      stim_q.push_back(b);
    end
  endtask

  task automatic drain();
    valid_pct = 100;
    ready_pct = 100;
    for (int i = 0; i < 400 && (stim_q.size() > 0 || exp_q.size() > 0); i++) step();
    chk("drain_bound", 32'(stim_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] data,
                         input logic [2:0] size, input logic last);
    word_t w;
    w = (idx < log_q.size()) ? log_q[idx] : '0;
    chk({name, "_data"}, w.data, data);
    chk({name, "_size"}, 32'(w.size), 32'(size));
    chk({name, "_last"}, 32'(w.last), 32'(last));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_din"}, din, 32'd0);
    chk({name, "_size"}, 32'(din_size), 32'd0);
    chk({name, "_last"}, 32'(din_last), 32'd0);
    chk({name, "_valid"}, 32'(din_valid), 32'd0);
    chk({name, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic do_reset();
    #1 arstn = 1'b0;
    #2 chk_reset_outputs("midreset");
    #1 arstn = 1'b1;
    stim_q.delete();
    exp_q.delete();
    cur_q.delete();
    n_pops = 0;
    n_msgs = 0;
  endtask

  initial begin
    int unsigned a0;
    beat_t b;

    #3 chk_reset_outputs("reset");
    @(negedge clk);
    #2 arstn = 1'b1;

    // Five bytes, last on 0x55: one full word then a one-byte final word.
    log_q.delete();
    push_bytes(8'h11, 1, 1'b0); push_bytes(8'h22, 1, 1'b0); push_bytes(8'h33, 1, 1'b0);
    push_bytes(8'h44, 1, 1'b0); push_bytes(8'h55, 1, 1'b1);
    a0 = n_acc;
    repeat (5) step();
    chk("s1_accept5", 32'(n_acc - a0), 32'd5);
    drain();
    chk("s1_nwords", 32'(log_q.size()), 32'd2);
    chk_log("s1_w0", 0, 32'h44332211, 3'd4, 1'b0);
    chk_log("s1_w1", 1, 32'h00000055, 3'd1, 1'b1);

    // Zero-length message.
    log_q.delete();
    b.data = 8'hEE; b.empty = 1'b1; b.last = 1'b1;
    stim_q.push_back(b);
    drain();
    chk("s2_nwords", 32'(log_q.size()), 32'd1);
    chk_log("s2_w0", 0, 32'h0, 3'd0, 1'b1);

    // Exactly one full word: no trailing empty word.
    log_q.delete();
    push_bytes(8'hA0, 4, 1'b1);
    drain();
    repeat (4) step();
    chk("s3_nwords", 32'(log_q.size()), 32'd1);
    chk_log("s3_w0", 0, 32'hA3A2A1A0, 3'd4, 1'b1);

    // Backpressure: eight bytes absorbed, then stall until release.
    log_q.delete();
    push_bytes(8'hC0, 12, 1'b1);
    ready_pct = 0;
    a0 = n_acc;
    repeat (20) step();
    chk("s4_stall8", 32'(n_acc - a0), 32'd8);
    drain();
    chk("s4_nwords", 32'(log_q.size()), 32'd3);
    chk_log("s4_w0", 0, 32'hC3C2C1C0, 3'd4, 1'b0);
    chk_log("s4_w1", 1, 32'hC7C6C5C4, 3'd4, 1'b0);
    chk_log("s4_w2", 2, 32'hCBCAC9C8, 3'd4, 1'b1);
    log_q.delete();
    push_bytes(8'hD0, 16, 1'b1);
    a0 = n_acc;
    repeat (16) step();
    chk("s4_rate16", 32'(n_acc - a0), 32'd16);
    drain();
    chk("s4_nwords2", 32'(log_q.size()), 32'd4);

    // One-byte words on the G=1 instance.
    step(); s1_valid = 1'b1; s1_data = 8'h01; s1_last = 1'b0;
    step(); chk("g1_ready", 32'(s1_ready), 32'd1); s1_data = 8'h02; s1_last = 1'b1;
    step(); s1_valid = 1'b0;
    chk("g1_w0_valid", 32'(d1_valid), 32'd1);
    chk("g1_w0_data", d1, 32'h01);
    chk("g1_w0_size", 32'(d1_size), 32'd1);
    chk("g1_w0_last", 32'(d1_last), 32'd0);
    step();
    chk("g1_w1_valid", 32'(d1_valid), 32'd1);
    chk("g1_w1_data", d1, 32'h02);
    chk("g1_w1_size", 32'(d1_size), 32'd1);
    chk("g1_w1_last", 32'(d1_last), 32'd1);
    step();
    chk("g1_idle", 32'(d1_valid), 32'd0);

    // Reset in the middle of a word discards it.
    log_q.delete();
    push_bytes(8'h31, 2, 1'b0);
    repeat (3) step();
    do_reset();
    push_bytes(8'h7F, 1, 1'b1);
    drain();
    repeat (2) step();
    chk("s6_nwords", 32'(log_q.size()), 32'd1);
    chk_log("s6_w0", 0, 32'h0000007F, 3'd1, 1'b1);

    // Random traffic with empty beats and random backpressure.
    for (int i = 0; i < 300; i++) begin
      b.data  = 8'($urandom);
      b.empty = $urandom_range(9) == 0;
      b.last  = ($urandom_range(6) == 0) || (i == 299);
      stim_q.push_back(b);
    end
    valid_pct = 70;
    ready_pct = 60;
    for (int i = 0; i < 3000 && stim_q.size() > 0; i++) step();
    chk("rand_bound", 32'(stim_q.size()), 32'd0);
    drain();
    repeat (2) step();
    chk("rand_partial", 32'(cur_q.size()), 32'd0);

`ifdef SUBTERRANEAN_DIN_PACKER_STATS_EN
    chk("word_count", 32'(word_count), 32'(n_pops));
    chk("msg_count", 32'(msg_count), 32'(n_msgs));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
